mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates an instruction-fetch port and a data port onto one shared
// memory port. Only one transaction is outstanding at a time.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   iReq, iAddr              fetch request / address (held until iDone)
//   iRdata, iDone, iStall    fetch result, one-cycle completion pulse, stall
//   dReq, dWr, dAddr, dWdata data request, 1=write, address, write data
//   dRdata, dDone, dStall    data result, one-cycle completion pulse, stall
//   memEn, memWr, memAddr,   shared memory issue (memEn high for exactly
//   memWdata                 the issue cycle)
//   memRdata, memBusy,       memory read data, not-ready, completion
//   memDone
//   err                      sticky timeout flag, cleared only by reset
//   stateDbg                 current FSM state, for observation only
//
// Handshake: a requester raises xReq with stable address/data and holds
// them until the cycle xDone is high; xDone is a one-cycle pulse, and the
// requester is ineligible for issue during that pulse so a still-held
// request is not issued twice. The memory side sees memEn for one cycle
// (only while memBusy is low) and answers later with a one-cycle memDone.
module mem_arbiter #(
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [15:0] iAddr,
  output logic [15:0] iRdata,
  output logic        iDone,
  output logic        iStall,
  input  logic        dReq,
  input  logic        dWr,
  input  logic [15:0] dAddr,
  input  logic [15:0] dWdata,
  output logic [15:0] dRdata,
  output logic        dDone,
  output logic        dStall,
  output logic        memEn,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memWdata,
  input  logic [15:0] memRdata,
  input  logic        memBusy,
  input  logic        memDone,
  output logic        err,
  output logic [1:0]  stateDbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  // Abort fires in the TIMEOUT-th BUSY cycle without memDone.
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [SW-1:0] starveCnt;
  logic [TW-1:0] toCnt;
  logic          busyWr;   // outstanding data transaction is a write

  logic iElig, dElig, issue, pickI, busy, timeoutHit;

  assign stateDbg = state;
  assign iStall   = iReq & ~iDone;
  assign dStall   = dReq & ~dDone;

  always_comb begin
    iElig      = iReq & ~iDone;
    dElig      = dReq & ~dDone;
    // rst gates issue explicitly so memEn stays low for the whole reset.
    issue      = (state == IDLE) & ~memBusy & ~rst & (iElig | dElig);
    // Data has priority unless the fetch side has been passed over enough.
    pickI      = iElig & (~dElig | (starveCnt == STARVE_MAX));
    busy       = (state == BUSY_I) | (state == BUSY_D);
    timeoutHit = busy & ~memDone & (toCnt == TO_LAST);

    memEn    = issue;
    memWr    = 1'b0;
    memAddr  = 16'h0000;
    memWdata = 16'h0000;
    if (issue) begin
      if (pickI) begin
        memAddr = iAddr;
      end else begin
        memWr    = dWr;
        memAddr  = dAddr;
        memWdata = dWdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      starveCnt <= '0;
      toCnt     <= '0;
      busyWr    <= 1'b0;
      iDone     <= 1'b0;
      dDone     <= 1'b0;
      iRdata    <= 16'h0000;
      dRdata    <= 16'h0000;
      err       <= 1'b0;
    end else begin
      iDone <= (state == BUSY_I) & (memDone | timeoutHit);
      dDone <= (state == BUSY_D) & (memDone | timeoutHit);

      case (state)
        IDLE: begin
          // memDone is ignored here: nothing is outstanding.
          if (issue) begin
            state  <= pickI ? BUSY_I : BUSY_D;
            toCnt  <= '0;
            busyWr <= ~pickI & dWr;
            if (pickI) begin
              starveCnt <= '0;
            end else if (iReq && (starveCnt != STARVE_MAX)) begin
              starveCnt <= starveCnt + 1'b1;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (memDone) begin
            state <= IDLE;
            if (state == BUSY_I) begin
              iRdata <= memRdata;
            end else if (!busyWr) begin
              dRdata <= memRdata;
            end
          end else if (timeoutHit) begin
            state <= IDLE;
            err   <= 1'b1;
            if (state == BUSY_I) begin
              iRdata <= 16'h0000;
            end else begin
              dRdata <= 16'h0000;
            end
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iReq, dReq, dWr, memBusy, memDone;
  logic [15:0] iAddr, dAddr, dWdata, memRdata;
  logic [15:0] iRdata, dRdata, memAddr, memWdata;
  logic        iDone, iStall, dDone, dStall, memEn, memWr, err;
  logic [1:0]  stateDbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  mem_arbiter #(.STARVE_LIM(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAddr(iAddr), .iRdata(iRdata), .iDone(iDone), .iStall(iStall),
    .dReq(dReq), .dWr(dWr), .dAddr(dAddr), .dWdata(dWdata),
    .dRdata(dRdata), .dDone(dDone), .dStall(dStall),
    .memEn(memEn), .memWr(memWr), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memBusy(memBusy), .memDone(memDone),
    .err(err), .stateDbg(stateDbg)
  );

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pop_exp();
    if (exp_q.size() == 0) return 16'hxxxx;
    return exp_q.pop_front();
  endfunction

  initial begin
    rst = 1'b1;
    iReq = 0; dReq = 0; dWr = 0; memBusy = 0; memDone = 0;
    iAddr = 0; dAddr = 0; dWdata = 0; memRdata = 0;
    step(); step();

    // Reset state, with a request pending: no issue during reset.
    iReq = 1'b1; iAddr = 16'h0010; #1;
    check("rst_mem_en", 16'(memEn), 16'd0);
    check("rst_i_done", 16'(iDone), 16'd0);
    check("rst_d_done", 16'(dDone), 16'd0);
    check("rst_i_rdata", iRdata, 16'h0000);
    check("rst_d_rdata", dRdata, 16'h0000);
    check("rst_err", 16'(err), 16'd0);
    check("rst_state", 16'(stateDbg), 16'd0);

    // Single fetch, memDone two cycles after issue.
    step(); rst = 1'b0; #1;
    check("t1_mem_en", 16'(memEn), 16'd1);
    check("t1_mem_addr", memAddr, 16'h0010);
    check("t1_mem_wr", 16'(memWr), 16'd0);
    check("t1_mem_wdata", memWdata, 16'h0000);
    check("t1_i_stall", 16'(iStall), 16'd1);
    step(); #1;
    check("t1_busy_no_en", 16'(memEn), 16'd0);
    check("t1_state_busy_i", 16'(stateDbg), 16'd1);
    step(); memDone = 1'b1; memRdata = 16'hBEEF; exp_q.push_back(16'hBEEF); #1;
    check("t1_no_early_done", 16'(iDone), 16'd0);
    step(); memDone = 1'b0; #1;
    check("t1_i_done", 16'(iDone), 16'd1);
    check("t1_i_rdata", iRdata, pop_exp());
    check("t1_i_stall_low", 16'(iStall), 16'd0);
    check("t1_no_reissue", 16'(memEn), 16'd0);
    step(); iReq = 1'b0; #1;
    check("t1_done_pulse", 16'(iDone), 16'd0);
    check("t1_rdata_hold", iRdata, 16'hBEEF);

    // Both request from reset: data first, fetch in the dDone cycle.
    rst = 1'b1; iReq = 1'b1; iAddr = 16'h0020; dReq = 1'b1; dWr = 1'b0; dAddr = 16'h0200;
    step(); rst = 1'b0; #1;
    check("t2_data_first", memAddr, 16'h0200);
    check("t2_data_rd", 16'(memWr), 16'd0);
    step(); memDone = 1'b1; memRdata = 16'h1111;
    step(); memDone = 1'b0; #1;
    check("t2_d_done", 16'(dDone), 16'd1);
    check("t2_d_rdata", dRdata, 16'h1111);
    check("t2_instr_en", 16'(memEn), 16'd1);
    check("t2_instr_addr", memAddr, 16'h0020);
    step(); dReq = 1'b0; memDone = 1'b1; memRdata = 16'h2222;
    step(); memDone = 1'b0; iReq = 1'b0; #1;
    check("t2_i_done", 16'(iDone), 16'd1);
    check("t2_i_rdata", iRdata, 16'h2222);

    // Starvation: four data issues while the fetch waits, then the fetch.
    // memBusy is raised in each done cycle so both sides compete afterwards.
    rst = 1'b1; iReq = 1'b1; iAddr = 16'h0030; dReq = 1'b1; dAddr = 16'h0300; memRdata = 16'hAAAA;
    step(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      memBusy = 1'b0; memDone = 1'b0; #1;
      check("t3_data_en", 16'(memEn), 16'd1);
      check("t3_data_issue", memAddr, 16'h0300);
      step(); memDone = 1'b1;
      step(); memDone = 1'b0; memBusy = 1'b1; #1;
      check("t3_d_done", 16'(dDone), 16'd1);
      check("t3_busy_block", 16'(memEn), 16'd0);
      step();
    end
    memBusy = 1'b0; #1;
    check("t3_instr_en", 16'(memEn), 16'd1);
    check("t3_instr_issue", memAddr, 16'h0030);
    step(); memDone = 1'b1;
    step(); memDone = 1'b0; memBusy = 1'b1; #1;
    check("t3_i_done", 16'(iDone), 16'd1);
    check("t3_i_rdata", iRdata, 16'hAAAA);
    step(); memBusy = 1'b0; #1;
    check("t3_counter_cleared", memAddr, 16'h0300);
    iReq = 1'b0;
    step(); memDone = 1'b1;
    step(); memDone = 1'b0; dReq = 1'b0; #1;
    check("t3_last_d_done", 16'(dDone), 16'd1);
    step();

    // Data read 0x5555, then a write that must leave dRdata alone.
    dReq = 1'b1; dWr = 1'b0; dAddr = 16'h0050; #1;
    check("t4_rd_en", 16'(memEn), 16'd1);
    step(); memDone = 1'b1; memRdata = 16'h5555;
    step(); memDone = 1'b0; dReq = 1'b0; #1;
    check("t4_rd_rdata", dRdata, 16'h5555);
    step(); dReq = 1'b1; dWr = 1'b1; dAddr = 16'h0040; dWdata = 16'h1234; #1;
    check("t4_wr_en", 16'(memEn), 16'd1);
    check("t4_wr_flag", 16'(memWr), 16'd1);
    check("t4_wr_addr", memAddr, 16'h0040);
    check("t4_wr_wdata", memWdata, 16'h1234);
    step(); memDone = 1'b1; memRdata = 16'hDEAD;
    step(); memDone = 1'b0; dReq = 1'b0; dWr = 1'b0; #1;
    check("t4_wr_done", 16'(dDone), 16'd1);
    check("t4_wr_keeps_rdata", dRdata, 16'h5555);

    // Timeout on a fetch, then normal service with err held.
    step(); iReq = 1'b1; iAddr = 16'h0070; #1;
    check("t5_issue", 16'(memEn), 16'd1);
    check("t5_err_before", 16'(err), 16'd0);
    for (int b = 1; b <= 15; b++) begin
      step(); #1;
      check("t5_no_early_done", 16'(iDone), 16'd0);
    end
    check("t5_err_not_yet", 16'(err), 16'd0);
    step(); iReq = 1'b0; exp_q.push_back(16'h0000); #1;
    check("t5_timeout_done", 16'(iDone), 16'd1);
    check("t5_timeout_rdata", iRdata, pop_exp());
    check("t5_err_set", 16'(err), 16'd1);
    step(); dReq = 1'b1; dAddr = 16'h0080; #1;
    check("t5_after_en", 16'(memEn), 16'd1);
    check("t5_after_addr", memAddr, 16'h0080);
    step(); memDone = 1'b1; memRdata = 16'h7777;
    step(); memDone = 1'b0; dReq = 1'b0; #1;
    check("t5_after_done", 16'(dDone), 16'd1);
    check("t5_after_rdata", dRdata, 16'h7777);
    check("t5_err_sticky", 16'(err), 16'd1);

    // Reset in the middle of a data read, then a stray memDone.
    step(); dReq = 1'b1; dAddr = 16'h0090; #1;
    check("t6_issue", 16'(memEn), 16'd1);
    step(); #1;
    check("t6_state_busy_d", 16'(stateDbg), 16'd2);
    rst = 1'b1; #1;
    check("t6_rst_en", 16'(memEn), 16'd0);
    check("t6_rst_d_done", 16'(dDone), 16'd0);
    check("t6_rst_d_rdata", dRdata, 16'h0000);
    check("t6_rst_i_rdata", iRdata, 16'h0000);
    check("t6_rst_err", 16'(err), 16'd0);
    check("t6_rst_state", 16'(stateDbg), 16'd0);
    step(); rst = 1'b0; dReq = 1'b0; memDone = 1'b1; memRdata = 16'h4444;
    step(); memDone = 1'b0; #1;
    check("t6_stray_d_done", 16'(dDone), 16'd0);
    check("t6_stray_i_done", 16'(iDone), 16'd0);
    check("t6_stray_rdata", dRdata, 16'h0000);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
